// File: rtl/key_light_ctrl.sv
// key_light_ctrl: key pickup / light-switch sequencer for the three play stages.
// Tracks keys collected per stage, the stage-2 light state and its timeout,
// and produces the pickup flash window and the stage-clear pulse.
module key_light_ctrl #(
    parameter int HOLD_FRAMES  = 8,
    parameter int FLASH_FRAMES = 16,
    parameter int LIGHT_FRAMES = 600,
    parameter int HIT_MARGIN   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic       frame_tick,
    input  logic [8:0] player_x,
    input  logic [8:0] player_y,
    input  logic       act_btn,
    output logic [1:0] key_find,
    output logic       isDark,
    output logic       pickup_flash,
    output logic       stage_clear
);
    localparam int HOLD_W  = $clog2(HOLD_FRAMES + 1);
    localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
    localparam int LIGHT_W = $clog2(LIGHT_FRAMES + 1);

    localparam logic [3:0] STAGE1 = 4'd2;
    localparam logic [3:0] STAGE2 = 4'd4;
    localparam logic [3:0] STAGE3 = 4'd6;

    localparam logic signed [9:0] MARGIN_S = 10'(HIT_MARGIN);
    localparam logic signed [9:0] BOX_S    = 10'sd10;

    typedef enum logic [2:0] {IDLE, SEARCH, HOLD, FLASH, DONE} fsm_t;

    fsm_t               fsm_reg;
    logic [3:0]         prev_state_reg;
    logic [HOLD_W-1:0]  hold_cnt_reg;
    logic [FLASH_W-1:0] flash_cnt_reg;
    logic [LIGHT_W-1:0] light_cnt_reg;

    logic [8:0] key_ox;
    logic [8:0] key_oy;
    logic       key_valid;
    logic       stage_play;
    logic       key_hit;
    logic       sw_hit;
    logic       light_run;
    logic       light_expire;
    logic       dark_after_timer;
    logic       sw_toggle;
    logic       stage_entry;

    // Padded box test done in 10-bit signed so a negative lower edge does not wrap.
    function automatic logic box_hit(input logic [8:0] ox, input logic [8:0] oy,
                                     input logic [8:0] px, input logic [8:0] py);
        logic signed [9:0] sx, sy, lo_x, hi_x, lo_y, hi_y;
        sx   = $signed({1'b0, px});
        sy   = $signed({1'b0, py});
        lo_x = $signed({1'b0, ox}) - MARGIN_S;
        hi_x = $signed({1'b0, ox}) + BOX_S + MARGIN_S;
        lo_y = $signed({1'b0, oy}) - MARGIN_S;
        hi_y = $signed({1'b0, oy}) + BOX_S + MARGIN_S;
        return (sx >= lo_x) && (sx < hi_x) && (sy >= lo_y) && (sy < hi_y);
    endfunction

    // Origin of the key currently being searched for in this stage.
    always_comb begin
        key_ox    = 9'd0;
        key_oy    = 9'd0;
        key_valid = 1'b1;
        case (state)
            STAGE1: case (key_find)
                2'd0:    begin key_ox = 9'd70;  key_oy = 9'd40;  end
                2'd1:    begin key_ox = 9'd250; key_oy = 9'd40;  end
                2'd2:    begin key_ox = 9'd215; key_oy = 9'd220; end
                default: key_valid = 1'b0;
            endcase
            STAGE2: case (key_find)
                2'd0:    begin key_ox = 9'd130; key_oy = 9'd40;  end
                2'd1:    begin key_ox = 9'd220; key_oy = 9'd70;  end
                2'd2:    begin key_ox = 9'd215; key_oy = 9'd130; end
                default: key_valid = 1'b0;
            endcase
            STAGE3: case (key_find)
                2'd0:    begin key_ox = 9'd230; key_oy = 9'd40;  end
                2'd1:    begin key_ox = 9'd100; key_oy = 9'd110; end
                2'd2:    begin key_ox = 9'd160; key_oy = 9'd160; end
                default: key_valid = 1'b0;
            endcase
            default: key_valid = 1'b0;
        endcase
    end

    assign stage_play  = (state == STAGE1) || (state == STAGE2) || (state == STAGE3);
    assign stage_entry = (state != prev_state_reg);

    // Stage-2 key 0 sits in the dark room and can only be found with the light on.
    assign key_hit = key_valid && box_hit(key_ox, key_oy, player_x, player_y) &&
                     !((state == STAGE2) && (key_find == 2'd0) && isDark);
    assign sw_hit  = (state == STAGE2) && box_hit(9'd67, 9'd220, player_x, player_y);

    // Light timer is applied first; a same-cycle switch press then toggles the
    // post-expiry value, so pressing as the light dies turns it straight back on.
    assign light_run        = (state == STAGE2) && !isDark && frame_tick && (light_cnt_reg != '0);
    assign light_expire     = light_run && (light_cnt_reg == LIGHT_W'(1));
    assign dark_after_timer = isDark | light_expire;
    assign sw_toggle        = (fsm_reg == SEARCH) && act_btn && !key_hit && sw_hit;

    // Main sequencer: stage entry, light timer and pickup FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg        <= IDLE;
            prev_state_reg <= 4'd0;
            hold_cnt_reg   <= '0;
            flash_cnt_reg  <= '0;
            light_cnt_reg  <= '0;
            key_find       <= 2'd0;
            isDark         <= 1'b1;
            pickup_flash   <= 1'b0;
            stage_clear    <= 1'b0;
        end else begin
            prev_state_reg <= state;
            stage_clear    <= 1'b0;
            if (stage_entry) begin
                fsm_reg       <= stage_play ? SEARCH : IDLE;
                hold_cnt_reg  <= '0;
                flash_cnt_reg <= '0;
                light_cnt_reg <= '0;
                key_find      <= 2'd0;
                pickup_flash  <= 1'b0;
                if (state == STAGE2) begin
                    isDark <= 1'b1;
                end else if (stage_play) begin
                    isDark <= 1'b0;
                end
            end else begin
                if (light_run) begin
                    light_cnt_reg <= light_cnt_reg - LIGHT_W'(1);
                end
                if (light_expire) begin
                    isDark <= 1'b1;
                end
                case (fsm_reg)
                    SEARCH: begin
                        if (act_btn && key_hit) begin
                            fsm_reg      <= HOLD;
                            hold_cnt_reg <= '0;
                        end else if (sw_toggle) begin
                            isDark <= ~dark_after_timer;
                            if (dark_after_timer) begin
                                light_cnt_reg <= LIGHT_W'(LIGHT_FRAMES);
                            end
                        end
                    end
                    HOLD: begin
                        if (!key_hit) begin
                            fsm_reg <= SEARCH;
                        end else if (frame_tick) begin
                            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                            if (hold_cnt_reg == HOLD_W'(HOLD_FRAMES - 1)) begin
                                if (key_find != 2'd3) begin
                                    key_find <= key_find + 2'd1;
                                end
                                pickup_flash  <= 1'b1;
                                flash_cnt_reg <= '0;
                                fsm_reg       <= FLASH;
                            end
                        end
                    end
                    FLASH: begin
                        if (frame_tick) begin
                            flash_cnt_reg <= flash_cnt_reg + FLASH_W'(1);
                            if (flash_cnt_reg == FLASH_W'(FLASH_FRAMES - 1)) begin
                                pickup_flash <= 1'b0;
                                if (key_find == 2'd3) begin
                                    fsm_reg     <= DONE;
                                    stage_clear <= 1'b1;
                                end else begin
                                    fsm_reg <= SEARCH;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_key_light_ctrl.sv
// tb_key_light_ctrl: scoreboard bench for key_light_ctrl. A behavioural model
// predicts the outputs after every clock edge and queues them; a monitor pops
// and compares on the falling edge.
module tb_key_light_ctrl;
    localparam int HOLD  = 8;
    localparam int FLASH = 16;
    localparam int LIGHT = 600;
    localparam int HM    = 4;

    logic       clk;
    logic       rst;
    logic [3:0] state;
    logic       frame_tick;
    logic [8:0] player_x;
    logic [8:0] player_y;
    logic       act_btn;
    logic [1:0] key_find;
    logic       isDark;
    logic       pickup_flash;
    logic       stage_clear;

    key_light_ctrl dut (
        .clk(clk), .rst(rst), .state(state), .frame_tick(frame_tick),
        .player_x(player_x), .player_y(player_y), .act_btn(act_btn),
        .key_find(key_find), .isDark(isDark), .pickup_flash(pickup_flash),
        .stage_clear(stage_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kf;
        int dark;
        int flash;
        int clear;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Key origins per stage (rows) and key index (columns).
    int kx [3][3] = '{'{70, 250, 215}, '{130, 220, 215}, '{230, 100, 160}};
    int ky [3][3] = '{'{40, 40, 220},  '{40, 70, 130},   '{40, 110, 160}};

    localparam int P_IDLE = 0, P_SEARCH = 1, P_HOLD = 2, P_FLASH = 3, P_DONE = 4;
    int m_prev, m_keys, m_dark, m_flash, m_clear, m_phase;
    int m_frames_on_key, m_flash_left, m_light_left;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, got, want);
        end
    endtask

    function automatic int sidx(input logic [3:0] s);
        if (s == 4'd2) return 0;
        if (s == 4'd4) return 1;
        if (s == 4'd6) return 2;
        return -1;
    endfunction

    function automatic bit in_box(input int ox, input int oy);
        int px;
        int py;
        px = int'(player_x);
        py = int'(player_y);
        return (px >= ox - HM) && (px < ox + 10 + HM) && (py >= oy - HM) && (py < oy + 10 + HM);
    endfunction

    task automatic model_reset();
        m_prev = 0; m_keys = 0; m_dark = 1; m_flash = 0; m_clear = 0;
        m_phase = P_IDLE; m_frames_on_key = 0; m_flash_left = 0; m_light_left = 0;
    endtask

    // Predict outputs after one clock edge from the inputs present at that edge.
    task automatic model_edge();
        exp_t e;
        int   si;
        bit   kh;
        bit   sh;
        int   dark_t;
        cyc++;
        m_clear = 0;
        si = sidx(state);
        if (int'(state) != m_prev) begin
            m_keys = 0; m_frames_on_key = 0; m_flash_left = 0; m_light_left = 0; m_flash = 0;
            m_phase = (si >= 0) ? P_SEARCH : P_IDLE;
            if (si == 1) m_dark = 1;
            else if (si >= 0) m_dark = 0;
        end else begin
            kh = 0;
            if (si >= 0 && m_keys < 3) begin
                kh = in_box(kx[si][m_keys], ky[si][m_keys]);
                if (si == 1 && m_keys == 0 && m_dark == 1) kh = 0;
            end
            sh = (si == 1) && in_box(67, 220);
            dark_t = m_dark;
            if (si == 1 && m_dark == 0 && frame_tick && m_light_left > 0) begin
                m_light_left--;
                if (m_light_left == 0) dark_t = 1;
            end
            m_dark = dark_t;
            case (m_phase)
                P_SEARCH: begin
                    if (act_btn && kh) begin
                        m_phase = P_HOLD;
                        m_frames_on_key = 0;
                    end else if (act_btn && sh) begin
                        m_dark = 1 - dark_t;
                        if (m_dark == 0) m_light_left = LIGHT;
                    end
                end
                P_HOLD: begin
                    if (!kh) m_phase = P_SEARCH;
                    else if (frame_tick) begin
                        m_frames_on_key++;
                        if (m_frames_on_key == HOLD) begin
                            m_keys++;
                            m_flash = 1;
                            m_flash_left = FLASH;
                            m_phase = P_FLASH;
                        end
                    end
                end
                P_FLASH: begin
                    if (frame_tick) begin
                        m_flash_left--;
                        if (m_flash_left == 0) begin
                            m_flash = 0;
                            if (m_keys == 3) begin
                                m_phase = P_DONE;
                                m_clear = 1;
                            end else begin
                                m_phase = P_SEARCH;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
        m_prev = int'(state);
        e.kf = m_keys; e.dark = m_dark; e.flash = m_flash; e.clear = m_clear;
        exp_q.push_back(e);
    endtask

    // Monitor: one scoreboard entry per clock edge, compared on the falling edge.
    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (!rst) begin
                chk("key_find", int'(key_find), mon_e.kf);
                chk("isDark", int'(isDark), mon_e.dark);
                chk("pickup_flash", int'(pickup_flash), mon_e.flash);
                chk("stage_clear", int'(stage_clear), mon_e.clear);
            end
        end
    end

    task automatic step(input bit ft, input bit act);
        frame_tick = ft;
        act_btn    = act;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        frame_tick = 1'b0;
        act_btn    = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0);
            repeat ($urandom_range(1, 3)) step(1'b0, 1'b0);
        end
    endtask

    task automatic place(input int x, input int y);
        player_x = 9'(x);
        player_y = 9'(y);
    endtask

    task automatic pickup(input int x, input int y);
        place(x, y);
        step(1'b0, 1'b1);
        frames(HOLD);
        frames(FLASH + 1);
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge.
    task automatic async_reset_check();
        @(posedge clk);
        model_edge();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_key_find", int'(key_find), 0);
        chk("async_rst_isDark", int'(isDark), 1);
        chk("async_rst_pickup_flash", int'(pickup_flash), 0);
        chk("async_rst_stage_clear", int'(stage_clear), 0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int tx, ty, si, r;
        rst = 1'b1; state = 4'd0; frame_tick = 1'b0; act_btn = 1'b0;
        player_x = 9'd0; player_y = 9'd0;
        model_reset();
        #1;
        chk("init_key_find", int'(key_find), 0);
        chk("init_isDark", int'(isDark), 1);
        chk("init_pickup_flash", int'(pickup_flash), 0);
        chk("init_stage_clear", int'(stage_clear), 0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        // STAGE1: first key, then reset while holding on the second key.
        state = 4'd2;
        step(1'b0, 1'b0);
        pickup(72, 42);
        place(252, 42);
        step(1'b0, 1'b1);
        frames(3);
        async_reset_check();

        // STAGE1 again: walk off mid-hold, margin-edge misses, then all three keys.
        step(1'b0, 1'b0);
        place(72, 42);
        step(1'b0, 1'b1);
        frames(3);
        place(100, 100);
        step(1'b0, 1'b0);
        frames(HOLD);
        place(65, 42); step(1'b0, 1'b1); frames(HOLD + 1);
        place(84, 42); step(1'b0, 1'b1); frames(HOLD + 1);
        place(70, 35); step(1'b0, 1'b1); frames(HOLD + 1);
        pickup(66, 36);
        pickup(263, 53);
        pickup(217, 222);
        frames(3);
        place(72, 42); step(1'b0, 1'b1); frames(HOLD + 2);

        // STAGE2: dark key unreachable, light on, timeout, expiry during hold.
        state = 4'd4;
        step(1'b0, 1'b0);
        place(130, 40); step(1'b0, 1'b1); frames(HOLD + 1);
        place(70, 222); step(1'b0, 1'b1);
        frames(LIGHT);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        frames(LIGHT - 5);
        place(130, 40); step(1'b0, 1'b1);
        frames(HOLD + 2);
        // Switch pressed on the very frame the light expires.
        place(70, 222); step(1'b0, 1'b1);
        frames(LIGHT - 1);
        step(1'b1, 1'b1);
        frames(3);
        step(1'b0, 1'b1);
        frames(2);
        step(1'b0, 1'b1);
        pickup(130, 40);
        pickup(220, 70);

        // STAGE3 with two keys, then switch to STAGE2.
        state = 4'd6;
        step(1'b0, 1'b0);
        pickup(230, 40);
        pickup(100, 110);
        state = 4'd4;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        state = 4'd0;
        step(1'b0, 1'b0);
        frames(2);

        // Randomized play across stages, biased toward the current key.
        state = 4'd2;
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                r = $urandom_range(0, 4);
                state = (r == 4) ? 4'd3 : 4'(2 * r);
            end
            if ($urandom_range(0, 19) == 0) begin
                si = sidx(state);
                if (si >= 0 && m_keys < 3 && $urandom_range(0, 1) == 1) begin
                    tx = kx[si][m_keys]; ty = ky[si][m_keys];
                end else begin
                    r = $urandom_range(0, 9);
                    if (r < 9) begin tx = kx[r / 3][r % 3]; ty = ky[r / 3][r % 3]; end
                    else begin tx = 67; ty = 220; end
                end
                place(tx + $urandom_range(0, 21) - 6, ty + $urandom_range(0, 21) - 6);
            end
            step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
        end

        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
